// File: rtl/uc_select_nway.sv
// uc_select_nway: N-way redundant processor supervisor with retrying resets and non-preemptive failover.
module uc_select_nway #(
  parameter int N_UC        = 4,
  parameter int SEL_W       = 2,
  parameter int WD_TIMEOUT  = 1000,
  parameter int RST_PULSE   = 16,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_UC-1:0]  error_uc,
  input  logic [N_UC-1:0]  mon1_uc,
  input  logic [N_UC-1:0]  mon2_uc,
  output logic [N_UC-1:0]  reset_uc,
  output logic [SEL_W-1:0] selected_processor,
  output logic             selected_valid,
  output logic [N_UC-1:0]  failed,
  output logic             all_failed,
  output logic             failover_pulse
);
  typedef enum logic [1:0] {RUN, PULSE, RECOVER, DEAD} state_t;
  localparam logic [CNT_W-1:0] WD_T = CNT_W'(WD_TIMEOUT);
  localparam logic [CNT_W-1:0] PL   = CNT_W'(RST_PULSE - 1);
  localparam logic [3:0]       MR   = 4'(MAX_RETRIES);
  logic [N_UC-1:0] err_a, err_s, m1_a, m1_s, m1_p, m2_a, m2_s, m2_p, e1, e2, run;
  logic [SEL_W-1:0] low;
  logic any;
  function automatic logic [CNT_W-1:0] tick(input logic e, input logic [CNT_W-1:0] w);
    return e ? '0 : (w < WD_T ? w + 1'b1 : w);
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      {err_a, err_s, m1_a, m1_s, m1_p, m2_a, m2_s, m2_p} <= '0;
    end else begin
      {err_a, err_s} <= {error_uc, err_a};
      {m1_a, m1_s, m1_p} <= {mon1_uc, m1_a, m1_s};
      {m2_a, m2_s, m2_p} <= {mon2_uc, m2_a, m2_s};
    end
  end
  assign e1 = m1_s ^ m1_p;
  assign e2 = m2_s ^ m2_p;
  for (genvar c = 0; c < N_UC; c++) begin : g_ch
    state_t st, st_n;
    logic [CNT_W-1:0] wd1, wd2, pc, wd1_n, wd2_n, pc_n;
    logic [3:0] rt, rt_n;
    logic sn1, sn2, sn1_n, sn2_n, fault;
    always_comb begin
      fault = err_s[c] || wd1 >= WD_T || wd2 >= WD_T;
      st_n = st;
      rt_n = rt;
      pc_n = '0;
      wd1_n = tick(e1[c], wd1);
      wd2_n = tick(e2[c], wd2);
      sn1_n = st == RECOVER && (sn1 || e1[c]);
      sn2_n = st == RECOVER && (sn2 || e2[c]);
      if (st == PULSE) begin
        wd1_n = '0;
        wd2_n = '0;
        pc_n = pc == PL ? '0 : pc + 1'b1;
        st_n = pc == PL ? RECOVER : PULSE;
      end else if (st == DEAD) begin
        wd1_n = '0;
        wd2_n = '0;
      end else if (fault) begin
        st_n = rt < MR ? PULSE : DEAD;
        rt_n = rt < MR ? rt + 1'b1 : rt;
        wd1_n = '0;
        wd2_n = '0;
        sn1_n = 1'b0;
        sn2_n = 1'b0;
      end else if (st == RECOVER && sn1 && sn2) begin
        st_n = RUN;
        wd1_n = '0;
        wd2_n = '0;
        sn1_n = 1'b0;
        sn2_n = 1'b0;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st <= RUN;
        rt <= '0;
        pc <= '0;
        wd1 <= '0;
        wd2 <= '0;
        sn1 <= 1'b0;
        sn2 <= 1'b0;
      end else begin
        st <= st_n;
        rt <= rt_n;
        pc <= pc_n;
        wd1 <= wd1_n;
        wd2 <= wd2_n;
        sn1 <= sn1_n;
        sn2 <= sn2_n;
      end
    end
    assign reset_uc[c] = st == PULSE || st == DEAD;
    assign failed[c]   = st == DEAD;
    assign run[c]      = st == RUN;
  end
  // scan downward so the last hit is the lowest running index
  always_comb begin
    low = '0;
    any = 1'b0;
    for (int i = N_UC - 1; i >= 0; i--) begin
      if (run[i]) begin
        low = SEL_W'(i);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      selected_processor <= '0;
      selected_valid <= 1'b1;
      failover_pulse <= 1'b0;
      all_failed <= 1'b0;
    end else begin
      all_failed <= &failed;
      failover_pulse <= 1'b0;
      if (selected_valid && !run[selected_processor]) begin
        selected_processor <= any ? low : selected_processor;
        selected_valid <= any;
        failover_pulse <= any;
      end else if (!selected_valid && any) begin
        selected_processor <= low;
        selected_valid <= 1'b1;
        failover_pulse <= low != selected_processor;
      end
    end
  end
endmodule
